store_monitor: RTL

- Synthesizable self-check stage that sits directly downstream of the MIPS `top` data-memory write port.
- Samples every store the core issues (memwrite, aluout, writedata) and compares it against the program's expected store pattern.
- Latches a sticky pass/fail verdict with a cause code, and flags a timeout if the core never produces the terminating store.
- Lets the processor be checked on FPGA or in any bench without a behavioural checker.

---
 rtl/store_monitor.sv | 82 ++++++++
 1 files changed

// File: rtl/store_monitor.sv
// Self-check stage on the core's data-memory write port: samples every store,
// matches it against the expected store pattern and latches a sticky verdict.
module store_monitor #(
  parameter int unsigned PASS_ADDR  = 84,
  parameter int unsigned PASS_DATA  = 7,
  parameter int unsigned ALLOW_ADDR = 80,
  parameter int unsigned TIMEOUT    = 1000,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memwrite,
  input  logic [31:0]      aluout,
  input  logic [31:0]      writedata,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [1:0]       fail_code,
  output logic [CNT_W-1:0] store_count,
  output logic [CNT_W-1:0] cycle_count,
  output logic [31:0]      last_addr,
  output logic [31:0]      last_data
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PASS = 2'd1,
    FAIL = 2'd2
  } state_t;

  localparam logic [31:0]      PASS_A  = 32'(PASS_ADDR);
  localparam logic [31:0]      PASS_D  = 32'(PASS_DATA);
  localparam logic [31:0]      ALLOW_A = 32'(ALLOW_ADDR);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [1:0]       CODE_STORE   = 2'd1;
  localparam logic [1:0]       CODE_TIMEOUT = 2'd2;

  state_t state;

  // Only RUN evaluates inputs; PASS and FAIL hold every output until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      fail_code   <= 2'd0;
      store_count <= '0;
      cycle_count <= '0;
      last_addr   <= '0;
      last_data   <= '0;
    end else if (state == RUN) begin
      if (memwrite) begin
        last_addr <= aluout;
        last_data <= writedata;
        if (aluout == PASS_A && writedata == PASS_D) begin
          state <= PASS;
          done  <= 1'b1;
          pass  <= 1'b1;
        end else if (aluout == ALLOW_A) begin
          if (store_count != '1)
            store_count <= store_count + ONE;
        end else begin
          state     <= FAIL;
          done      <= 1'b1;
          fail      <= 1'b1;
          fail_code <= CODE_STORE;
        end
      end else if (cycle_count == TO_LAST) begin
        // A store on this edge would have won; an idle edge here is the timeout.
        state     <= FAIL;
        done      <= 1'b1;
        fail      <= 1'b1;
        fail_code <= CODE_TIMEOUT;
      end else begin
        cycle_count <= cycle_count + ONE;
      end
    end
  end

endmodule
